// File: rtl/fmv_frame_presenter_pkg.sv
// Shared FMV types: planar YUV frame descriptor, presenter FSM states and the
// MPEG-1 picture_rate to integer frames-per-second lookup.
package fmv_frame_presenter_pkg;

  typedef struct packed {
    logic [19:0] y;
    logic [19:0] u;
    logic [19:0] v;
  } planar_yuv_s;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL_WAIT,
    RUN,
    POP,
    SETTLE1,
    SETTLE2,
    RELEASE2
  } state_e;

  // A result of 0 means "unsupported code, hold the current frame".
  function automatic logic [6:0] rate_fps(input logic [3:0] code);
    logic [6:0] fps;
    case (code)
      4'd1, 4'd2: fps = 7'd24;
      4'd3:       fps = 7'd25;
      4'd4, 4'd5: fps = 7'd30;
      4'd6:       fps = 7'd50;
      4'd7, 4'd8: fps = 7'd60;
      default:    fps = 7'd0;
    endcase
    return fps;
  endfunction

endpackage

// File: rtl/fmv_frame_presenter.sv
// Paces decoded frames from MPEG picture rate to display field rate, holds the
// displayed frame for the fetcher and returns superseded frames to the pool.
module fmv_frame_presenter
  import fmv_frame_presenter_pkg::*;
#(
  parameter int PREFILL = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  picture_rate,
  input  logic        disp_60hz,
  input  logic        vsync,
  input  logic        fifo_valid,
  input  planar_yuv_s fifo_q,
  input  logic [4:0]  fifo_cnt,
  output logic        fifo_strobe,
  output planar_yuv_s disp_frame,
  output logic        disp_valid,
  output logic        release_we,
  output planar_yuv_s release_adr,
  output logic [7:0]  underrun_cnt
);

  state_e      state, state_next;
  logic [6:0]  acc, acc_next;
  logic [1:0]  due, due_next;
  logic [6:0]  fps;
  logic [7:0]  disp8;
  logic [7:0]  sum;
  logic        do_pop;
  logic        do_underrun;
  logic        do_stop_release;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      due   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      due   <= due_next;
    end
  end

  // Two SETTLE cycles after every pop give the registered FIFO time to present
  // its new head, which also bounds strobes to one per three cycles.
  always_comb begin
    fps             = rate_fps(picture_rate);
    disp8           = disp_60hz ? 8'd60 : 8'd50;
    sum             = {1'b0, acc} + {1'b0, fps};
    state_next      = state;
    acc_next        = acc;
    due_next        = due;
    fifo_strobe     = 1'b0;
    do_pop          = 1'b0;
    do_underrun     = 1'b0;
    do_stop_release = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = PREFILL_WAIT;
      end
      PREFILL_WAIT: begin
        if (!enable) begin
          state_next = RELEASE2;
        end else if (vsync && (fifo_cnt >= 5'(PREFILL))) begin
          due_next   = 2'd1;
          acc_next   = '0;
          state_next = POP;
        end
      end
      RUN: begin
        if (!enable) begin
          state_next = RELEASE2;
        end else if (vsync && (fps != 7'd0)) begin
          if (sum < disp8) begin
            acc_next = sum[6:0];
          end else if (sum < (disp8 << 1)) begin
            due_next   = 2'd1;
            acc_next   = 7'(sum - disp8);
            state_next = POP;
          end else begin
            due_next   = 2'd2;
            acc_next   = 7'(sum - (disp8 << 1));
            state_next = POP;
          end
        end
      end
      POP: begin
        if (fifo_valid) begin
          fifo_strobe = 1'b1;
          do_pop      = 1'b1;
          state_next  = SETTLE1;
        end else begin
          // Parking acc just below the threshold retries the pop next field.
          do_underrun = 1'b1;
          acc_next    = 7'(disp8 - 8'd1);
          due_next    = '0;
          state_next  = RUN;
        end
      end
      SETTLE1: begin
        state_next = SETTLE2;
      end
      SETTLE2: begin
        due_next = due - 2'd1;
        if (!enable)              state_next = RELEASE2;
        else if (due == 2'd2)     state_next = POP;
        else                      state_next = RUN;
      end
      RELEASE2: begin
        do_stop_release = 1'b1;
        acc_next        = '0;
        due_next        = '0;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_frame   <= '0;
      disp_valid   <= 1'b0;
      release_we   <= 1'b0;
      release_adr  <= '0;
      underrun_cnt <= '0;
    end else begin
      release_we <= 1'b0;
      if (do_pop) begin
        disp_frame <= fifo_q;
        disp_valid <= 1'b1;
        if (disp_valid) begin
          release_we  <= 1'b1;
          release_adr <= disp_frame;
        end
      end
      if (do_underrun && (underrun_cnt != 8'hFF)) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
      if (do_stop_release) begin
        disp_valid <= 1'b0;
        if (disp_valid) begin
          release_we  <= 1'b1;
          release_adr <= disp_frame;
        end
      end
    end
  end

endmodule

// File: tb/tb_fmv_frame_presenter.sv
// Scoreboard bench for fmv_frame_presenter: stimulus queues expected pops and
// releases with their cycle numbers, a negedge monitor matches DUT events.
module tb_fmv_frame_presenter;
  import fmv_frame_presenter_pkg::*;

  localparam int PREFILL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  picture_rate;
  logic        disp_60hz;
  logic        vsync;
  logic        fifo_valid;
  planar_yuv_s fifo_q;
  logic [4:0]  fifo_cnt;
  logic        fifo_strobe;
  planar_yuv_s disp_frame;
  logic        disp_valid;
  logic        release_we;
  planar_yuv_s release_adr;
  logic [7:0]  underrun_cnt;

  typedef struct {
    int          cyc;
    planar_yuv_s f;
  } ev_t;

  ev_t         pop_q[$];
  ev_t         rel_q[$];
  planar_yuv_s fq[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_strobes = 0;
  int          exp_id = 1;
  int          push_id = 1;
  bit          shown = 1'b0;
  bit          starve = 1'b0;
  bit          disp_pend = 1'b0;
  planar_yuv_s disp_exp;

  fmv_frame_presenter #(.PREFILL(PREFILL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .picture_rate(picture_rate),
    .disp_60hz(disp_60hz), .vsync(vsync), .fifo_valid(fifo_valid),
    .fifo_q(fifo_q), .fifo_cnt(fifo_cnt), .fifo_strobe(fifo_strobe),
    .disp_frame(disp_frame), .disp_valid(disp_valid), .release_we(release_we),
    .release_adr(release_adr), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  function automatic planar_yuv_s mk(input int k);
    planar_yuv_s r;
    r.y = 20'(32'h1000 * k);
    r.u = 20'(32'h1000 * k + 32'h800);
    r.v = 20'(32'h1000 * k + 32'hC00);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Registered FIFO model: head, valid and count follow a pop by one cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_strobe && fq.size() > 0) fq.delete(0);
    fifo_q     <= (fq.size() > 0) ? fq[0] : '0;
    fifo_valid <= (fq.size() > 0) && !starve;
    fifo_cnt   <= (fq.size() > 31) ? 5'd31 : 5'(fq.size());
  end

  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (disp_pend) begin
        checkOutput("disp_frame", 64'(disp_frame), 64'(disp_exp));
        checkOutput("disp_valid", 64'(disp_valid), 64'd1);
        disp_pend = 1'b0;
      end
      if (fifo_strobe) begin
        n_strobes++;
        checkOutput("strobe_fifo_valid", 64'(fifo_valid), 64'd1);
        if (pop_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("[TB] FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
        end else begin
          e = pop_q.pop_front();
          checkOutput("strobe_cycle", 64'(cyc), 64'(e.cyc));
          disp_exp  = e.f;
          disp_pend = 1'b1;
        end
      end
      if (release_we) begin
        if (rel_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("[TB] FAIL unexpected_release: got release %h at cycle %0d expected none", release_adr, cyc);
        end else begin
          e = rel_q.pop_front();
          checkOutput("release_cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("release_adr", 64'(release_adr), 64'(e.f));
        end
      end
    end
  end

  // One vsync; npops is the hand-derived number of frames this field consumes.
  task automatic applyStimulus(input int npops, input bit refill);
    int  n;
    ev_t e;
    if (refill) begin
      while (fq.size() < 4) begin
        fq.push_back(mk(push_id));
        push_id++;
      end
    end
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    n = cyc;
    for (int i = 0; i < npops; i++) begin
      e.cyc = n + 1 + 3 * i;
      e.f   = mk(exp_id);
      pop_q.push_back(e);
      if (shown) begin
        e.cyc = n + 2 + 3 * i;
        e.f   = mk(exp_id - 1);
        rel_q.push_back(e);
      end
      shown = 1'b1;
      exp_id++;
    end
    @(negedge clk);
    vsync = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int  s0;
    int  m;
    ev_t e;
    reset        = 1'b0;
    enable       = 1'b0;
    vsync        = 1'b0;
    picture_rate = 4'd3;
    disp_60hz    = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_fifo_strobe", 64'(fifo_strobe), 64'd0);
    checkOutput("rst_disp_valid", 64'(disp_valid), 64'd0);
    checkOutput("rst_disp_frame", 64'(disp_frame), 64'd0);
    checkOutput("rst_release_we", 64'(release_we), 64'd0);
    checkOutput("rst_release_adr", 64'(release_adr), 64'd0);
    checkOutput("rst_underrun_cnt", 64'(underrun_cnt), 64'd0);
    checkOutput("rst_state", 64'(dut.state), 64'(IDLE));
    reset = 1'b0;

    // Prefill: one frame is not enough, the second one starts presentation.
    enable = 1'b1;
    fq.push_back(mk(push_id));
    push_id++;
    repeat (3) @(negedge clk);
    applyStimulus(0, 1'b0);
    fq.push_back(mk(push_id));
    push_id++;
    applyStimulus(1, 1'b0);

    // 25 fps on 50 Hz: every second field.
    s0 = n_strobes;
    for (int k = 0; k < 10; k++) applyStimulus(k % 2, 1'b1);
    checkOutput("pops_25_on_50", 64'(n_strobes - s0), 64'd5);

    // 60 fps on 50 Hz: acc 60,70,80,90 then 100 drops one frame.
    picture_rate = 4'd7;
    s0 = n_strobes;
    for (int k = 0; k < 5; k++) applyStimulus((k == 4) ? 2 : 1, 1'b1);
    checkOutput("pops_60_on_50", 64'(n_strobes - s0), 64'd6);

    // 24 fps on 60 Hz: a pop whenever floor(24k/60) steps.
    picture_rate = 4'd1;
    disp_60hz    = 1'b1;
    s0 = n_strobes;
    for (int k = 1; k <= 60; k++) applyStimulus((24 * k) / 60 - (24 * (k - 1)) / 60, 1'b1);
    checkOutput("pops_24_on_60", 64'(n_strobes - s0), 64'd24);

    // Underrun on a due field, then the retry on the following field.
    picture_rate = 4'd8;
    starve = 1'b1;
    applyStimulus(0, 1'b1);
    checkOutput("underrun_cnt", 64'(underrun_cnt), 64'd1);
    checkOutput("underrun_disp_frame", 64'(disp_frame), 64'(mk(exp_id - 1)));
    checkOutput("underrun_disp_valid", 64'(disp_valid), 64'd1);
    starve = 1'b0;
    applyStimulus(1, 1'b1);
    checkOutput("underrun_cnt_hold", 64'(underrun_cnt), 64'd1);

    // Stop: displayed frame goes back to the pool.
    @(negedge clk);
    enable = 1'b0;
    m = cyc;
    e.cyc = m + 2;
    e.f   = mk(exp_id - 1);
    rel_q.push_back(e);
    shown = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("stop_disp_valid", 64'(disp_valid), 64'd0);
    checkOutput("stop_state", 64'(dut.state), 64'(IDLE));

    // Restart and hit reset in SETTLE1.
    enable = 1'b1;
    while (fq.size() < 4) begin
      fq.push_back(mk(push_id));
      push_id++;
    end
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    e.cyc = cyc + 1;
    e.f   = mk(exp_id);
    pop_q.push_back(e);
    exp_id++;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_state", 64'(dut.state), 64'(IDLE));
    checkOutput("midrst_fifo_strobe", 64'(fifo_strobe), 64'd0);
    checkOutput("midrst_disp_valid", 64'(disp_valid), 64'd0);
    checkOutput("midrst_disp_frame", 64'(disp_frame), 64'd0);
    checkOutput("midrst_release_we", 64'(release_we), 64'd0);
    checkOutput("midrst_release_adr", 64'(release_adr), 64'd0);
    checkOutput("midrst_underrun_cnt", 64'(underrun_cnt), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("pending_pops", 64'(pop_q.size()), 64'd0);
    checkOutput("pending_releases", 64'(rel_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
